sr_flipflop: RTL and testbench
==============================

SR_FLIPFLOP -- requirements
Module: sr_flipflop

Interface
REQ-001 The module SHALL be named sr_flipflop and SHALL have ports in the positional order clk, rst, s, r, q, qbar.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with the clock port named clk and the reset port named rst.
REQ-003 Parameter RESET_VAL, default 1'b0: the value loaded into q while rst is low.
REQ-004 Parameter BOTH_MODE, default 0: action taken when s=r=1 (0 = hold, 1 = reset-dominant, 2 = set-dominant).
REQ-005 clk  input  1  rising-edge clock; all non-reset state changes SHALL occur only on this edge.
REQ-006 rst  input  1  asynchronous reset, active low.
REQ-007 s  input  1  set request, sampled on the rising edge of clk.
REQ-008 r  input  1  reset (clear) request, sampled on the rising edge of clk.
REQ-009 q  output  1  registered state.
REQ-010 qbar  output  1  complement of q.

Function
REQ-011 q SHALL be a single flip-flop, and qbar SHALL equal ~q at all times, including during reset.
REQ-012 On each rising clk edge while rst=1, q SHALL be updated according to REQ-013 to REQ-016.
REQ-013 s=0, r=0: q SHALL hold its value.
REQ-014 s=0, r=1: q SHALL become 0.
REQ-015 s=1, r=0: q SHALL become 1.
REQ-016 s=1, r=1: q SHALL hold when BOTH_MODE=0, become 0 when BOTH_MODE=1, and become 1 when BOTH_MODE=2.
REQ-017 Any other BOTH_MODE value SHALL behave as BOTH_MODE=0.
REQ-018 Latency SHALL be one clock: the new q SHALL be visible after the sampling edge, with no combinational path from s or r to q or qbar.
REQ-019 Changes on s and r between clock edges SHALL have no effect on q.
REQ-020 q and qbar SHALL never be X or Z after the first reset or the first valid clock edge.

Reset
REQ-021 When rst goes low, q SHALL go to RESET_VAL and qbar to ~RESET_VAL immediately, without waiting for a clock edge.
REQ-022 While rst is low, q SHALL be held at RESET_VAL regardless of clk, s and r.
REQ-023 Reset SHALL override any simultaneous clock edge.
REQ-024 On rst deassertion (low to high), q SHALL keep RESET_VAL until the first rising clk edge at which rst=1.
REQ-025 At that first edge, q SHALL take the value given by the s/r table; no extra idle cycle SHALL be inserted.
REQ-026 Reset asserted mid-operation SHALL discard the current state.

Verification
REQ-027 Clock with a 40 ns period, defaults, rst=0 with s/r=01 and then 10 for 40 ns each -> q=0 and qbar=1 throughout, unaffected by the s=1 edge.
REQ-028 rst=1 with s/r=00 -> q=0 and qbar=1 held; then s/r=01 -> q=0.
REQ-029 rst=1 with s/r=10 -> q=1 and qbar=0 after the next rising edge, not before it.
REQ-030 Pulse s=1 between clock edges (glitch) -> q unchanged.
REQ-031 rst=1 with s/r=11 from q=1 -> q stays 1 when BOTH_MODE=0, becomes 0 when BOTH_MODE=1, and becomes 1 when BOTH_MODE=2.
REQ-032 With q=1 and rst asserted mid-cycle, away from any edge -> q=0 immediately; after release, s/r=00 -> q stays 0; with RESET_VAL=1, reset -> q=1 and qbar=0.

Source files
------------

// File: rtl/sr_flipflop.sv
// Clocked SR flip-flop with asynchronous active-low reset and a configurable
// response to the simultaneous s=r=1 request.
module sr_flipflop #(
  parameter logic RESET_VAL = 1'b0,
  parameter int   BOTH_MODE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic qbar
);

  logic q_reg;
  logic q_next;

  // Unrecognised BOTH_MODE values fall through to hold.
  always_comb begin
    q_next = q_reg;
    unique case ({s, r})
      2'b00: q_next = q_reg;
      2'b01: q_next = 1'b0;
      2'b10: q_next = 1'b1;
      2'b11: begin
        if (BOTH_MODE == 1)
          q_next = 1'b0;
        else if (BOTH_MODE == 2)
          q_next = 1'b1;
        else
          q_next = q_reg;
      end
      default: q_next = q_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      q_reg <= RESET_VAL;
    else
      q_reg <= q_next;
  end

  assign q    = q_reg;
  assign qbar = ~q_reg;

endmodule

// File: tb/tb_sr_flipflop.sv
// Directed bench for sr_flipflop: four parameterisations driven in lockstep,
// expected q values queued at drive time and checked after the sampling edge.
module tb_sr_flipflop;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s   = 1'b0;
  logic r   = 1'b0;
  logic q0, q1, q2, q3;
  logic qb0, qb1, qb2, qb3;
  logic [3:0] qv, qbv;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [3:0] q;
  } sb_t;
  sb_t sb[$];

  // bit i of the model tracks instance i
  logic [3:0] model;

  always #20 clk = ~clk;

  assign qv  = {q3, q2, q1, q0};
  assign qbv = {qb3, qb2, qb1, qb0};

  sr_flipflop dut0 (.clk(clk), .rst(rst), .s(s), .r(r), .q(q0), .qbar(qb0));
  sr_flipflop #(.BOTH_MODE(1)) dut1 (.clk(clk), .rst(rst), .s(s), .r(r), .q(q1), .qbar(qb1));
  sr_flipflop #(.BOTH_MODE(2)) dut2 (.clk(clk), .rst(rst), .s(s), .r(r), .q(q2), .qbar(qb2));
  sr_flipflop #(.RESET_VAL(1'b1), .BOTH_MODE(3)) dut3 (.clk(clk), .rst(rst), .s(s), .r(r), .q(q3), .qbar(qb3));

  function automatic logic [3:0] nxt(input logic [3:0] cur, input logic sv, input logic rv);
    logic [3:0] n;
    for (int i = 0; i < 4; i++) begin
      case ({sv, rv})
        2'b01:   n[i] = 1'b0;
        2'b10:   n[i] = 1'b1;
        2'b11:   n[i] = (i == 1) ? 1'b0 : (i == 2) ? 1'b1 : cur[i];
        default: n[i] = cur[i];
      endcase
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_both(input string tag, input logic [3:0] exp);
    chk({tag, "_q"}, qv, exp);
    chk({tag, "_qbar"}, qbv, ~exp);
    $display("txn %-14s s=%b r=%b rst=%b q=%b qbar=%b", tag, s, r, rst, qv, qbv);
  endtask

  task automatic pop_check();
    sb_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty: observed=0 entries expected=1");
      return;
    end
    total--;
    e = sb.pop_front();
    chk_both(e.tag, e.q);
  endtask

  // Drive s/r at the falling edge, confirm nothing moves before the rising edge,
  // then compare against the queued expectation just after it.
  task automatic step(input logic sv, input logic rv, input string tag);
    sb_t e;
    @(negedge clk);
    s = sv;
    r = rv;
    #1;
    chk_both({tag, "_pre"}, model);
    model = nxt(model, sv, rv);
    e.tag = tag;
    e.q   = model;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sb_t e;
    // Reset asserted with s/r=01, then 10; clock edges must not disturb q.
    s = 1'b0; r = 1'b1;
    #1 rst = 1'b0;
    #1;
    model = 4'b1000;
    chk_both("rst_async", model);
    @(posedge clk); #1;
    chk_both("rst_edge_01", model);
    @(negedge clk);
    chk_both("rst_neg_01", model);
    s = 1'b1; r = 1'b0;
    @(posedge clk); #1;
    chk_both("rst_edge_10", model);
    @(negedge clk);
    chk_both("rst_neg_10", model);

    // Release; s/r=00 holds, then 01 clears every instance.
    rst = 1'b1; s = 1'b0; r = 1'b0;
    #1;
    chk_both("rel_hold", model);
    step(1'b0, 1'b0, "hold_00");
    step(1'b0, 1'b1, "clear_01");
    step(1'b1, 1'b0, "set_10");

    // Glitches on s and r between edges must be ignored.
    @(negedge clk);
    s = 1'b0; r = 1'b0;
    #5 r = 1'b1;
    #5 r = 1'b0;
    #5 s = 1'b1;
    #5 s = 1'b0;
    e.tag = "glitch"; e.q = model;
    sb.push_back(e);
    @(posedge clk); #1;
    pop_check();

    // Both requests from q=1, twice, then from q=0.
    step(1'b1, 1'b1, "both_from1");
    step(1'b1, 1'b1, "both_again");
    step(1'b0, 1'b1, "clear_01b");
    step(1'b1, 1'b1, "both_from0");

    // Mid-cycle reset from q=1 is immediate and ignores clock and inputs.
    step(1'b1, 1'b0, "set_10b");
    @(posedge clk);
    #7 rst = 1'b0;
    #1;
    model = 4'b1000;
    chk_both("mid_rst", model);
    s = 1'b1; r = 1'b0;
    @(posedge clk); #1;
    chk_both("mid_rst_edge", model);
    #5 rst = 1'b1; s = 1'b0; r = 1'b0;
    step(1'b0, 1'b0, "post_rel_00");

    // First edge after release obeys the table with no idle cycle.
    @(posedge clk);
    #5 rst = 1'b0;
    #1;
    chk_both("rst_again", model);
    #5 rst = 1'b1;
    step(1'b1, 1'b0, "first_edge_10");
    step(1'b0, 1'b0, "final_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
